// File: rtl/decode_opc_stream_pkg.sv
// Shared types and constants for the byte-serial opcode front end.
package decode_opc_stream_pkg;

  typedef enum logic [2:0] {
    S_PFX   = 3'd0,
    S_OPC2  = 3'd1,
    S_TAIL  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] PFX_ES     = 8'h26;
  localparam logic [7:0] PFX_CS     = 8'h2E;
  localparam logic [7:0] PFX_SS     = 8'h36;
  localparam logic [7:0] PFX_DS     = 8'h3E;
  localparam logic [7:0] PFX_FS     = 8'h64;
  localparam logic [7:0] PFX_GS     = 8'h65;
  localparam logic [7:0] PFX_OPSIZE = 8'h66;
  localparam logic [7:0] PFX_ADDR   = 8'h67;
  localparam logic [7:0] PFX_LOCK   = 8'hF0;
  localparam logic [7:0] PFX_REPNE  = 8'hF2;
  localparam logic [7:0] PFX_REP    = 8'hF3;

  localparam int unsigned PB_OPSIZE = 0;
  localparam int unsigned PB_LOCK   = 1;
  localparam int unsigned PB_REPNE  = 2;
  localparam int unsigned PB_REP    = 3;
  localparam int unsigned PB_SEG    = 4;
  localparam int unsigned PB_W      = 5;

  localparam logic [2:0] SEG_ES = 3'd0;
  localparam logic [2:0] SEG_CS = 3'd1;
  localparam logic [2:0] SEG_SS = 3'd2;
  localparam logic [2:0] SEG_DS = 3'd3;
  localparam logic [2:0] SEG_FS = 3'd4;
  localparam logic [2:0] SEG_GS = 3'd5;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_PREFIXES = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_TRUNC    = 2'd3;

endpackage

// File: rtl/decode_opc_stream_prefix_class.sv
// Combinational legacy-prefix classifier: byte -> prefix kind, flag one-hot,
// segment code and address-size marker.
module decode_prefix_class
  import decode_opc_stream_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       is_prefix,
  output logic [4:0] pfx_onehot,
  output logic [2:0] seg,
  output logic       is_addr16
);

  always_comb begin
    is_prefix  = 1'b1;
    pfx_onehot = '0;
    seg        = SEG_ES;
    is_addr16  = 1'b0;
    case (byte_in)
      PFX_ES:     begin pfx_onehot[PB_SEG] = 1'b1; seg = SEG_ES; end
      PFX_CS:     begin pfx_onehot[PB_SEG] = 1'b1; seg = SEG_CS; end
      PFX_SS:     begin pfx_onehot[PB_SEG] = 1'b1; seg = SEG_SS; end
      PFX_DS:     begin pfx_onehot[PB_SEG] = 1'b1; seg = SEG_DS; end
      PFX_FS:     begin pfx_onehot[PB_SEG] = 1'b1; seg = SEG_FS; end
      PFX_GS:     begin pfx_onehot[PB_SEG] = 1'b1; seg = SEG_GS; end
      PFX_OPSIZE: pfx_onehot[PB_OPSIZE] = 1'b1;
      PFX_ADDR:   is_addr16 = 1'b1;
      PFX_LOCK:   pfx_onehot[PB_LOCK] = 1'b1;
      PFX_REPNE:  pfx_onehot[PB_REPNE] = 1'b1;
      PFX_REP:    pfx_onehot[PB_REP] = 1'b1;
      default:    is_prefix = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_opc_stream.sv
// Byte-serial instruction front end: strips legacy prefixes, removes the
// two-byte escape and assembles the unescaped window for the opcode-map stage.
module decode_opc_stream
  import decode_opc_stream_pkg::*;
#(
  parameter int unsigned MAX_INSTR_BYTES = 9,
  parameter int unsigned MAX_PREFIXES    = 4,
  parameter logic [7:0]  ESCAPE_BYTE     = 8'h0F
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [7:0]                             in_byte,
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [8*MAX_INSTR_BYTES-1:0]           out_instr,
  output logic [$clog2(MAX_INSTR_BYTES+1)-1:0]   out_len,
  output logic                                   out_is_2byte,
  output logic [4:0]                             out_prefix,
  output logic                                   out_addr16,
  output logic [2:0]                             out_seg,
  output logic                                   out_err,
  output logic [1:0]                             out_err_code
);

  localparam int unsigned WIN_W = 8 * MAX_INSTR_BYTES;
  localparam int unsigned LEN_W = $clog2(MAX_INSTR_BYTES + 1);
  localparam int unsigned CNT_W = $clog2(MAX_PREFIXES + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIN_W-1:0]   win_d;
  logic [LEN_W-1:0]   len_d;
  logic               two_d, a16_d;
  logic [4:0]         pfx_d;
  logic [2:0]         seg_d;
  logic [1:0]         code_d;

  logic               pc_is_prefix, pc_is_addr16;
  logic [4:0]         pc_onehot;
  logic [2:0]         pc_seg;
  logic               acc;

  decode_prefix_class u_pfx (
    .byte_in    (in_byte),
    .is_prefix  (pc_is_prefix),
    .pfx_onehot (pc_onehot),
    .seg        (pc_seg),
    .is_addr16  (pc_is_addr16)
  );

  assign acc = in_valid & in_ready;

  // Next-state and next-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = out_instr;
    len_d   = out_len;
    two_d   = out_is_2byte;
    a16_d   = out_addr16;
    pfx_d   = out_prefix;
    seg_d   = out_seg;
    code_d  = out_err_code;

    if (state_q == S_DONE) begin
      if (out_ready) begin
        state_d = S_PFX;
        cnt_d   = '0;
        win_d   = '0;
        len_d   = '0;
        two_d   = 1'b0;
        a16_d   = 1'b0;
        pfx_d   = '0;
        seg_d   = '0;
        code_d  = ERR_NONE;
      end
    end else if (acc) begin
      case (state_q)
        S_PFX: begin
          if (pc_is_prefix) begin
            if (cnt_q == CNT_W'(MAX_PREFIXES)) begin
              code_d  = ERR_PREFIXES;
              state_d = in_last ? S_DONE : S_DRAIN;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
              pfx_d = out_prefix | pc_onehot;
              if (pc_onehot[PB_SEG]) seg_d = pc_seg;
              if (pc_is_addr16) a16_d = 1'b1;
              if (in_last) begin
                code_d  = ERR_TRUNC;
                state_d = S_DONE;
              end
            end
          end else if (in_byte == ESCAPE_BYTE) begin
            two_d = 1'b1;
            if (in_last) begin
              code_d  = ERR_TRUNC;
              state_d = S_DONE;
            end else begin
              state_d = S_OPC2;
            end
          end else begin
            win_d[7:0] = in_byte;
            len_d      = LEN_W'(1);
            state_d    = in_last ? S_DONE : S_TAIL;
          end
        end
        S_OPC2: begin
          win_d[7:0] = in_byte;
          len_d      = LEN_W'(1);
          state_d    = in_last ? S_DONE : S_TAIL;
        end
        S_TAIL: begin
          if (out_len == LEN_W'(MAX_INSTR_BYTES)) begin
            code_d  = ERR_OVERFLOW;
            state_d = in_last ? S_DONE : S_DRAIN;
          end else begin
            // Byte-enable on the current length selects the write lane.
            for (int unsigned i = 0; i < MAX_INSTR_BYTES; i++) begin
              if (LEN_W'(i) == out_len) win_d[i*8 +: 8] = in_byte;
            end
            len_d   = out_len + LEN_W'(1);
            state_d = in_last ? S_DONE : S_TAIL;
          end
        end
        S_DRAIN: begin
          if (in_last) state_d = S_DONE;
        end
        default: state_d = S_PFX;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_PFX;
      cnt_q        <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_len      <= '0;
      out_is_2byte <= 1'b0;
      out_prefix   <= '0;
      out_addr16   <= 1'b0;
      out_seg      <= '0;
      out_err      <= 1'b0;
      out_err_code <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in_ready     <= (state_d != S_DONE);
      out_valid    <= (state_d == S_DONE);
      out_instr    <= win_d;
      out_len      <= len_d;
      out_is_2byte <= two_d;
      out_prefix   <= pfx_d;
      out_addr16   <= a16_d;
      out_seg      <= seg_d;
      out_err      <= (code_d != ERR_NONE);
      out_err_code <= code_d;
    end
  end

endmodule
